// File: rtl/core_mem_responder.sv
// core_mem_responder: memory-side responder for the core memory interface.
// Unified word-addressed RAM serving instruction fetches and data accesses.
// Writes go to individual byte lanes. Each transfer has WAIT_STATES wait cycles,
// and a data request wins over a fetch requested in the same cycle.
//
// state  | meaning
// IDLE   | not busy; accepts a request (data request first)
// WAIT   | transfer accepted; counting down the wait states
// RESP   | one-cycle response pulse (instr_valid or data_ack, plus err)
module core_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  input  logic        instr_req_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic [31:0] addr_i,
  input  logic        data_req_i,
  input  logic [3:0]  wr_en_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic        data_ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  kind_q, kind_d;   // 1 = data transfer, 0 = fetch
  logic                  wr_q, wr_d;       // data transfer is a write
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           rd_data_q, rd_data_d;

  logic [31:0]           mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] data_idx;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  accept;
  logic                  wr_legal;
  logic                  do_write;
  logic                  load_rsp;
  logic                  unused_addr_bits;

  // Only the word-index bits matter; upper bits alias and the byte offset is ignored.
  assign data_idx  = addr_i[ADDR_WIDTH+1:2];
  assign fetch_idx = pc_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:ADDR_WIDTH+2], pc_i[31:ADDR_WIDTH+2]};

  function automatic logic lanes_legal(input logic [3:0] we);
    case (we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign accept   = (state_q == S_IDLE) && (data_req_i || instr_req_i);
  assign wr_legal = lanes_legal(wr_en_i);
  // Writes commit on the accept edge so any later read already sees the new data.
  assign do_write = accept && data_req_i && (wr_en_i != 4'b0000) && wr_legal;

  // Next-state, wait counter and response data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    load_rsp  = 1'b0;
    instr_d   = instr_q;
    rd_data_d = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          kind_d = data_req_i;
          idx_d  = data_req_i ? data_idx : fetch_idx;
          wr_d   = data_req_i && (wr_en_i != 4'b0000);
          err_d  = data_req_i ? !wr_legal : (pc_i[1:0] != 2'b00);
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            load_rsp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A misaligned fetch still returns the addressed word; writes leave rd_data alone.
    if (load_rsp) begin
      if (kind_d) begin
        if (!wr_d) rd_data_d = mem_q[idx_d];
      end else begin
        instr_d = mem_q[idx_d];
      end
    end
  end

  // Control and response registers; reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      kind_q    <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      instr_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      instr_q   <= instr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en_i[i]) mem_q[data_idx][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign instr_valid_o = (state_q == S_RESP) && !kind_q;
  assign data_ack_o    = (state_q == S_RESP) && kind_q;
  assign err_o         = (state_q == S_RESP) && err_q;
  assign instr_o       = instr_q;
  assign rd_data_o     = rd_data_q;

endmodule
